// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//   Fetch stage in front of the dual-issue decoder. Reads 64-bit instruction
//   pairs (two 32-bit words, low word = earlier instruction) from local store,
//   queues them in a small FIFO, and presents the FIFO head to the decoder.
//   Honours decoder back-pressure and flushes/redirects on a taken branch.
//
//   A read strobe in cycle k returns memData in cycle k+1. That data is pushed
//   at the end of k+1, so the pair can reach instOut in cycle k+2.
//
// Ports
//   clk           in   1            clock
//   reset         in   1            synchronous, active-high reset
//   stallIn       in   1            decoder busy: hold instOut, do not pop
//   branchTaken   in   1            redirect request (single-cycle pulse)
//   branchTarget  in   addrWidth    word address of redirect target
//   memRdEn       out  1            local-store read strobe
//   memAddr       out  addrWidth    word address of pair (bit 0 always 0)
//   memData       in   2*instWidth  read data, valid 1 cycle after memRdEn
//   instOut       out  2*instWidth  pair to decoder; all-ones = empty/NOP
//   instValid     out  1            instOut holds a real pair
//   pcOut         out  addrWidth    word address of instOut low word
// -----------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int addrWidth = 11,
    parameter int instWidth = 32,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stallIn,
    input  logic                   branchTaken,
    input  logic [addrWidth-1:0]   branchTarget,
    output logic                   memRdEn,
    output logic [addrWidth-1:0]   memAddr,
    input  logic [2*instWidth-1:0] memData,
    output logic [2*instWidth-1:0] instOut,
    output logic                   instValid,
    output logic [addrWidth-1:0]   pcOut
);

    localparam int PAIR_W = 2 * instWidth;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [PAIR_W-1:0] NOP_PAIR = '1;

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t state, state_next;

    logic [addrWidth-1:0] pc;
    logic                 rd_mask;     // read on the bus is an odd-target redirect fetch
    logic                 resp_valid;  // memData this cycle belongs to a live read
    logic [addrWidth-1:0] resp_addr;
    logic                 resp_mask;

    logic [PAIR_W-1:0]    fifo_data [DEPTH];
    logic [addrWidth-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_ptr_next;
    logic [CNT_W-1:0]     count, count_after_pop, count_next;
    logic [CNT_W:0]       credit;

    logic                 flush, push, pop, issue;
    logic [PAIR_W-1:0]    push_data, head_data;
    logic [addrWidth-1:0] head_pc, target_pair;
    logic                 head_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next      = state;
        flush           = branchTaken;
        push            = 1'b0;
        pop             = 1'b0;
        issue           = 1'b0;
        push_data       = memData;
        count_after_pop = count;
        count_next      = count;
        rd_ptr_next     = rd_ptr;
        credit          = '0;
        head_valid      = 1'b0;
        head_data       = NOP_PAIR;
        head_pc         = '0;
        target_pair     = {branchTarget[addrWidth-1:1], 1'b0};

        case (state)
            RUN:      if (branchTaken) state_next = REDIRECT;
            REDIRECT: state_next = branchTaken ? REDIRECT : RUN;
            default:  state_next = RUN;
        endcase

        // A flush discards both the arriving pair and any pop this cycle.
        push = resp_valid && !flush;
        pop  = instValid && !stallIn && !flush && (state == RUN);

        // Odd redirect target: the even word before it must not execute.
        if (resp_mask) push_data[instWidth-1:0] = '1;

        count_after_pop = count - CNT_W'(pop);
        count_next      = count_after_pop + CNT_W'(push);
        rd_ptr_next     = rd_ptr + PTR_W'(pop);

        // Reserve a slot for the read already on the bus so a push never
        // lands in a full FIFO.
        credit = {1'b0, count_next} + (CNT_W+1)'(memRdEn);
        issue  = (state == RUN) && !flush && (credit < (CNT_W+1)'(DEPTH));

        // Head after this edge: bypass the pushed pair into an empty FIFO.
        head_valid = (count_next != '0);
        if (count_after_pop == '0) begin
            if (push) begin
                head_data = push_data;
                head_pc   = resp_addr;
            end
        end else begin
            head_data = fifo_data[rd_ptr_next];
            head_pc   = fifo_pc[rd_ptr_next];
        end
    end

    // NOTE: the FIFO storage has no reset; count and pointers alone decide
    // which entries are live, so the storage never needs clearing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_pc[wr_ptr]   <= resp_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            memRdEn    <= 1'b0;
            memAddr    <= '0;
            rd_mask    <= 1'b0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_mask  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            instOut    <= NOP_PAIR;
            instValid  <= 1'b0;
            pcOut      <= '0;
        end else if (flush) begin
            // Refetch from the target immediately; the read on the bus now
            // is cancelled by dropping its response.
            pc         <= target_pair + addrWidth'(2);
            memRdEn    <= 1'b1;
            memAddr    <= target_pair;
            rd_mask    <= branchTarget[0];
            resp_valid <= 1'b0;
            resp_mask  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            instOut    <= NOP_PAIR;
            instValid  <= 1'b0;
            pcOut      <= '0;
        end else begin
            memRdEn    <= issue;
            if (issue) begin
                memAddr <= pc;
                pc      <= pc + addrWidth'(2);
            end
            rd_mask    <= 1'b0;
            resp_valid <= memRdEn;
            resp_addr  <= memAddr;
            resp_mask  <= rd_mask;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            instOut    <= head_data;
            instValid  <= head_valid;
            pcOut      <= head_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_buffer
//   Directed bench for inst_fetch_buffer. The local-store model returns word w
//   as the 32-bit value w, so the pair at even address a is {a+1, a}.
//   Stimulus pushes the expected pairs into a queue; a monitor pops and
//   compares whenever the decoder consumes a pair.
// -----------------------------------------------------------------------------
module tb_inst_fetch_buffer;

    localparam int AW = 11;
    localparam int IW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            stallIn;
    logic            branchTaken;
    logic [AW-1:0]   branchTarget;
    logic            memRdEn;
    logic [AW-1:0]   memAddr;
    logic [2*IW-1:0] memData;
    logic [2*IW-1:0] instOut;
    logic            instValid;
    logic [AW-1:0]   pcOut;

    inst_fetch_buffer #(.addrWidth(AW), .instWidth(IW), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallIn      (stallIn),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .memRdEn      (memRdEn),
        .memAddr      (memAddr),
        .memData      (memData),
        .instOut      (instOut),
        .instValid    (instValid),
        .pcOut        (pcOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*IW-1:0] inst;
        logic [AW-1:0]   pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] NOP = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [AW-1:0] a, input bit mask);
        exp_t r;
        r.inst = {32'(a | AW'(1)), mask ? 32'hFFFF_FFFF : 32'(a)};
        r.pc   = a;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Local store: sample the strobe mid-cycle, answer in the following cycle.
    logic          mem_rd_s;
    logic [AW-1:0] mem_addr_s;
    initial memData = 64'h0BAD_F00D_0BAD_F00D;
    always begin
        @(negedge clk);
        mem_rd_s   = memRdEn;
        mem_addr_s = memAddr;
        @(posedge clk);
        #1;
        memData = mem_rd_s ? {32'(mem_addr_s | AW'(1)), 32'(mem_addr_s)}
                           : 64'h0BAD_F00D_0BAD_F00D;
    end

    // Monitor: a pair is consumed when valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (!reset && instValid && !stallIn && !branchTaken && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("pair_data", instOut, mon_e.inst);
            check("pair_pc", 64'(pcOut), 64'(mon_e.pc));
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            next_cycle();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rden"},  64'(memRdEn),   64'd0);
        check({tag, "_addr"},  64'(memAddr),   64'd0);
        check({tag, "_inst"},  instOut,        NOP);
        check({tag, "_valid"}, 64'(instValid), 64'd0);
        check({tag, "_pc"},    64'(pcOut),     64'd0);
    endtask

    // Branch in cycle N; leaves the caller at the negedge of cycle N+1.
    task automatic redirect(input logic [AW-1:0] tgt, input bit rd_at_n, input logic [AW-1:0] exp_addr);
        branchTaken  = 1'b1;
        branchTarget = tgt;
        @(negedge clk);
        check("br_rd_before", 64'(memRdEn), 64'(rd_at_n));
        next_cycle();
        branchTaken = 1'b0;
        stallIn     = 1'b0;
        @(negedge clk);
        check("br_flush_valid", 64'(instValid), 64'd0);
        check("br_flush_nop",   instOut,        NOP);
        check("br_rd",          64'(memRdEn),   64'd1);
        check("br_addr",        64'(memAddr),   64'(exp_addr));
    endtask

    // From the negedge of N+1, move to N+3 and check the first target pair.
    task automatic check_first(input logic [63:0] pair);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("br_first_valid", 64'(instValid), 64'd1);
        check("br_first_pair",  instOut,        pair);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        reset        = 1'b1;
        stallIn      = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = '0;

        // Tests 1 and 2: streaming from reset, then a stall long enough to fill.
        for (int k = 0; k < 12; k++) exp_q.push_back(mk(AW'(2 * k), 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        next_cycle();               // cycle 0
        reset = 1'b0;
        @(negedge clk);
        check("c0_rden", 64'(memRdEn), 64'd0);
        next_cycle();               // cycle 1
        @(negedge clk);
        check("c1_rden", 64'(memRdEn), 64'd1);
        check("c1_addr", 64'(memAddr), 64'd0);
        next_cycle();               // cycle 2
        @(negedge clk);
        check("c2_valid", 64'(instValid), 64'd0);
        check("c2_addr",  64'(memAddr),   64'd2);
        next_cycle();               // cycle 3
        @(negedge clk);
        check("c3_valid", 64'(instValid), 64'd1);
        check("c3_inst",  instOut,        64'h0000_0001_0000_0000);
        next_cycle();               // cycle 4
        next_cycle();               // cycle 5
        stallIn = 1'b1;
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk);
            check("stall_hold", instOut, 64'h0000_0005_0000_0004);
            if (c >= 9) check("full_no_rd", 64'(memRdEn), 64'd0);
            next_cycle();
        end
        stallIn = 1'b0;             // cycle 11
        drain("drain_stream");

        // Test 3: redirect to 0x040 with a read on the bus.
        exp_q.push_back(mk(11'h040, 1'b0));
        exp_q.push_back(mk(11'h042, 1'b0));
        exp_q.push_back(mk(11'h044, 1'b0));
        exp_q.push_back(mk(11'h046, 1'b0));
        redirect(11'h040, 1'b1, 11'h040);
        check_first(64'h0000_0041_0000_0040);
        drain("drain_br040");

        // Test 4: odd target masks the low word.
        exp_q.push_back(mk(11'h040, 1'b1));
        exp_q.push_back(mk(11'h042, 1'b0));
        exp_q.push_back(mk(11'h044, 1'b0));
        redirect(11'h041, 1'b1, 11'h040);
        check_first(64'h0000_0041_FFFF_FFFF);
        drain("drain_br041");

        // Test 5: pc wrap at the top of local store.
        exp_q.push_back(mk(11'h7FE, 1'b0));
        exp_q.push_back(mk(11'h000, 1'b0));
        exp_q.push_back(mk(11'h002, 1'b0));
        redirect(11'h7FE, 1'b1, 11'h7FE);
        seen = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            next_cycle();
            @(negedge clk);
            if (memRdEn && !seen) begin
                seen = 1'b1;
                check("wrap_addr", 64'(memAddr), 64'd0);
            end
            if (i == 3) check("wrap_first_pair", instOut, 64'h0000_07FF_0000_07FE);
        end
        check("wrap_rd_seen", 64'(seen), 64'd1);
        drain("drain_wrap");

        // Reset mid-stream, then restart from address 0.
        next_cycle();
        reset = 1'b1;
        exp_q.push_back(mk(11'h000, 1'b0));
        exp_q.push_back(mk(11'h002, 1'b0));
        exp_q.push_back(mk(11'h004, 1'b0));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_first_pair", instOut, 64'h0000_0001_0000_0000);
        drain("drain_reset");

        // Test 6: branch and stall together with a full FIFO.
        stallIn = 1'b1;
        repeat (8) next_cycle();
        exp_q.push_back(mk(11'h100, 1'b0));
        exp_q.push_back(mk(11'h102, 1'b0));
        redirect(11'h100, 1'b0, 11'h100);
        check_first(64'h0000_0101_0000_0100);
        drain("drain_full_br");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
